// File: rtl/stopwatch_seg.sv
// Stopwatch counter with a 4-digit common-anode seven-segment scan driver.
// Counts M:SS.T in BCD from rising edges of a slow divided clock, which is
// sampled as data on clk_in. The optional lap-hold display feature is enabled
// by defining STOPWATCH_LAP_EN; it adds the btn_lap input.

module stopwatch_seg #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        tick_in,
    input  logic        btn_ss,
    input  logic        btn_clr,
`ifdef STOPWATCH_LAP_EN
    input  logic        btn_lap,
`endif
    output logic [15:0] count_bcd,
    output logic        running,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [19:0] ScanMax = 20'(SCAN_DIV - 1);

    // Synchronizer stages and previous-value registers for edge detection
    logic [1:0]  r_tick_sync;
    logic        r_tick_prev;
    logic [1:0]  r_ss_sync;
    logic        r_ss_prev;
    logic [1:0]  r_clr_sync;
    logic        r_clr_prev;

    logic        w_tick_p;
    logic        w_ss_p;
    logic        w_clr_p;

    // Stopwatch state
    logic [15:0] r_count;
    logic [15:0] w_count_d;
    logic [15:0] w_count_inc;
    logic        r_running;
    logic        w_running_d;

    // Scan state
    logic [19:0] r_scan_cnt;
    logic [19:0] w_scan_cnt_d;
    logic [1:0]  r_sel;
    logic [1:0]  w_sel_d;

    // Display path
    logic [15:0] w_disp;
    logic [3:0]  w_digit;
    logic [6:0]  w_seg_dec;
    logic [3:0]  w_an_dec;
    logic        w_dp_dec;
    logic [3:0]  r_an;
    logic [6:0]  r_seg;
    logic        r_dp;

    // Two-flop synchronizers plus previous-value registers on every input
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_tick_sync <= 2'b00;
            r_tick_prev <= 1'b0;
            r_ss_sync   <= 2'b00;
            r_ss_prev   <= 1'b0;
            r_clr_sync  <= 2'b00;
            r_clr_prev  <= 1'b0;
        end else begin
            r_tick_sync <= {r_tick_sync[0], tick_in};
            r_tick_prev <= r_tick_sync[1];
            r_ss_sync   <= {r_ss_sync[0], btn_ss};
            r_ss_prev   <= r_ss_sync[1];
            r_clr_sync  <= {r_clr_sync[0], btn_clr};
            r_clr_prev  <= r_clr_sync[1];
        end
    end

    assign w_tick_p = r_tick_sync[1] & ~r_tick_prev;
    assign w_ss_p   = r_ss_sync[1] & ~r_ss_prev;
    assign w_clr_p  = r_clr_sync[1] & ~r_clr_prev;

    // BCD increment with digit ranges 9:59.9, wrapping to 0:00.0
    always_comb begin
        w_count_inc = r_count;
        if (r_count[3:0] == 4'd9) begin
            w_count_inc[3:0] = 4'd0;
            if (r_count[7:4] == 4'd9) begin
                w_count_inc[7:4] = 4'd0;
                if (r_count[11:8] == 4'd5) begin
                    w_count_inc[11:8] = 4'd0;
                    if (r_count[15:12] == 4'd9) begin
                        w_count_inc[15:12] = 4'd0;
                    end else begin
                        w_count_inc[15:12] = r_count[15:12] + 4'd1;
                    end
                end else begin
                    w_count_inc[11:8] = r_count[11:8] + 4'd1;
                end
            end else begin
                w_count_inc[7:4] = r_count[7:4] + 4'd1;
            end
        end else begin
            w_count_inc[3:0] = r_count[3:0] + 4'd1;
        end
    end

    // Clear wins outright; a tick counts using run state from before any toggle
    always_comb begin
        w_count_d   = r_count;
        w_running_d = r_running;
        if (w_clr_p) begin
            w_count_d   = 16'h0000;
            w_running_d = 1'b0;
        end else begin
            if (w_tick_p && r_running) begin
                w_count_d = w_count_inc;
            end
            if (w_ss_p) begin
                w_running_d = ~r_running;
            end
        end
    end

    // Stopwatch count and run-state registers
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_count   <= 16'h0000;
            r_running <= 1'b0;
        end else begin
            r_count   <= w_count_d;
            r_running <= w_running_d;
        end
    end

    assign count_bcd = r_count;
    assign running   = r_running;

`ifdef STOPWATCH_LAP_EN
    logic [1:0]  r_lap_sync;
    logic        r_lap_prev;
    logic        w_lap_p;
    logic        r_hold;
    logic        w_hold_d;
    logic [15:0] r_snap;
    logic [15:0] w_snap_d;

    // Lap button synchronizer and edge detector
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_lap_sync <= 2'b00;
            r_lap_prev <= 1'b0;
        end else begin
            r_lap_sync <= {r_lap_sync[0], btn_lap};
            r_lap_prev <= r_lap_sync[1];
        end
    end

    assign w_lap_p = r_lap_sync[1] & ~r_lap_prev;

    // Lap toggles the hold; entering hold captures the live count
    always_comb begin
        w_hold_d = r_hold;
        w_snap_d = r_snap;
        if (w_clr_p) begin
            w_hold_d = 1'b0;
        end else if (w_lap_p) begin
            w_hold_d = ~r_hold;
            if (!r_hold) begin
                w_snap_d = r_count;
            end
        end
    end

    // Lap hold flag and snapshot registers
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_hold <= 1'b0;
            r_snap <= 16'h0000;
        end else begin
            r_hold <= w_hold_d;
            r_snap <= w_snap_d;
        end
    end

    assign w_disp = r_hold ? r_snap : r_count;
`else
    assign w_disp = r_count;
`endif

    // Scan divider: hold each digit SCAN_DIV cycles, then advance the select
    always_comb begin
        w_scan_cnt_d = r_scan_cnt + 20'd1;
        w_sel_d      = r_sel;
        if (r_scan_cnt == ScanMax) begin
            w_scan_cnt_d = 20'd0;
            w_sel_d      = r_sel + 2'd1;
        end
    end

    // Scan counter and digit select registers
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= 20'd0;
            r_sel      <= 2'd0;
        end else begin
            r_scan_cnt <= w_scan_cnt_d;
            r_sel      <= w_sel_d;
        end
    end

    // Select the digit, anode enable and decimal point for the current scan slot
    always_comb begin
        w_digit  = w_disp[3:0];
        w_an_dec = 4'b1110;
        w_dp_dec = 1'b1;
        unique case (r_sel)
            2'd0: begin
                w_digit  = w_disp[3:0];
                w_an_dec = 4'b1110;
            end
            2'd1: begin
                w_digit  = w_disp[7:4];
                w_an_dec = 4'b1101;
                w_dp_dec = 1'b0;  // point between SS and T
            end
            2'd2: begin
                w_digit  = w_disp[11:8];
                w_an_dec = 4'b1011;
            end
            2'd3: begin
                w_digit  = w_disp[15:12];
                w_an_dec = 4'b0111;
                w_dp_dec = 1'b0;  // point between M and SS
            end
            default: begin
                w_digit  = w_disp[3:0];
                w_an_dec = 4'b1110;
            end
        endcase
    end

    // Active-low segment decode, {g,f,e,d,c,b,a}
    always_comb begin
        w_seg_dec = 7'b1111111;
        case (w_digit)
            4'd0:    w_seg_dec = 7'b1000000;
            4'd1:    w_seg_dec = 7'b1111001;
            4'd2:    w_seg_dec = 7'b0100100;
            4'd3:    w_seg_dec = 7'b0110000;
            4'd4:    w_seg_dec = 7'b0011001;
            4'd5:    w_seg_dec = 7'b0010010;
            4'd6:    w_seg_dec = 7'b0000010;
            4'd7:    w_seg_dec = 7'b1111000;
            4'd8:    w_seg_dec = 7'b0000000;
            4'd9:    w_seg_dec = 7'b0010000;
            default: w_seg_dec = 7'b1111111;
        endcase
    end

    // Registered display outputs, one cycle behind select and count
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_an  <= 4'b1111;
            r_seg <= 7'b1111111;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_dec;
            r_seg <= w_seg_dec;
            r_dp  <= w_dp_dec;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

endmodule

// File: doc/stopwatch_seg.md
# stopwatch_seg

Stopwatch counter and 4-digit seven-segment display driver, the consumer of the slow square wave from the lab clock divider. Each rising edge of the divided clock is one 0.1 s tick; the block counts elapsed time as M:SS.T in BCD under start/stop/clear control and time-multiplexes the four digits onto a common-anode display. Everything runs on the fast board clock; the divided clock is treated as a data input, not as a clock.

## Interface
Parameters:
- SCAN_DIV, 1000: clk_in cycles each digit is displayed before the scan advances; legal range 2..2^20.

Ports:
- clk_in  in  1  fast board clock; all state on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tick_in  in  1  divided clock from the divider stage; each rising edge is one tick.
- btn_ss  in  1  start/stop button, debounced upstream, level.
- btn_clr  in  1  clear button, debounced upstream, level.
- count_bcd  out  16  {d3,d2,d1,d0} = minutes, tens of seconds, seconds, tenths.
- running  out  1  run state.
- an  out  4  digit enables, active-low, an[k] selects digit k.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- tick_in, btn_ss, btn_clr each pass through a 2-flop synchronizer followed by a previous-value register; rising-edge pulse = sync_q2 & ~prev, one clk_in cycle wide.
- Run state: a btn_ss pulse toggles running. A btn_clr pulse forces running=0 and zeroes all digits.
- Counting: on a tick pulse with running=1, increment BCD: d0 0..9; d0 carry into d1 0..9; d1 carry into d2 0..5; d2 carry into d3 0..9. At 9:59.9 a tick wraps all digits to 0:00.0; running stays 1.
- Simultaneous events in one cycle: clear beats tick and start/stop (result: zero, stopped). Tick with btn_ss pulse: the tick is counted (or not) using running as it was before the toggle.
- Ticks with running=0 are ignored; no tick is remembered.
- Scan: a 20-bit counter counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps and a 2-bit digit select advances 0→1→2→3→0.
- Output register each cycle: an = one-hot-low of select; seg = decode of selected digit (0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000); dp=0 only when select=1 (between SS and T) and also 0 when select=3 (between M and SS), else 1.

## Timing
- Reset values: count_bcd=16'h0000, running=0, an=4'b1111, seg=7'b1111111, dp=1, scan counter=0, select=0, synchronizer and prev flops=0.
- Input to pulse: an input rising edge sampled at clock edge E0 gives a pulse during the cycle after E1.
- count_bcd and running update at E2, which is 2 clk_in edges after the sampling edge.
- an/seg/dp are registered: they reflect select and count 1 cycle later. The first edge after reset release drives an=4'b1110 and seg=7'b1000000.
- Inputs must stay high and low for at least 2 clk_in cycles each; the divider output satisfies this.
- Reset asserted mid-count: all state returns to reset values immediately, independent of clk_in.

## Configuration
- STOPWATCH_LAP_EN defined: adds port btn_lap (in, 1, debounced, level), synchronized and edge-detected like the other buttons. Each btn_lap pulse toggles a lap-hold flag. On entering hold, count_bcd is copied into a snapshot register, and the display shows the snapshot while counting continues. A second pulse releases the hold and the live count is shown again. count_bcd always outputs the live count. Clear also releases the hold. The hold flag resets to 0.
- Not defined: no btn_lap port and no snapshot logic; the display always shows the live count.

## Test plan
- Reset, SCAN_DIV=4 → an steps 1110,1101,1011,0111 every 4 cycles; seg=1000000 on all digits; dp=0 only while an=1101 and an=0111.
- btn_ss pulse, then 25 tick_in edges → count_bcd=16'h0025, running=1; count changes exactly 2 edges after each sampled tick edge.
- Preload to 9:59.9 (running, 5999 ticks) then one tick → count_bcd=16'h0000, running stays 1.
- btn_clr rises in the same cycle a tick pulse would occur → count_bcd=0, running=0; later ticks are ignored.
- Assert rst mid-count at 0:12.3 → all outputs reach their reset values asynchronously; after release the count restarts from 0 only after a btn_ss pulse.
- With STOPWATCH_LAP_EN: lap at 0:01.0, 10 more ticks → display digits show 0010 while count_bcd=0020; second lap → display shows 0020.
